// File: rtl/safety_island_boot_ctrl.sv
// Boot sequencer for the safety island core: holds the core in reset, picks the boot
// source, validates the entry point and releases fetch, with timeout and restart paths.
module safety_island_boot_ctrl #(
    parameter logic [31:0] BaseAddr      = 32'h6000_0000,
    parameter logic [31:0] BootROMOffset = 32'h0000_1000,
    parameter logic [31:0] MemOffset     = 32'h0020_0000,
    parameter logic [31:0] MemBytes      = 32'h0001_0000,
    parameter int unsigned ResetCycles   = 4,
    parameter logic [31:0] TimeoutCycles = 32'd1_000_000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [1:0]  bootmode_i,
    input  logic        fetch_en_req_i,
    input  logic        entry_valid_i,
    input  logic [31:0] entry_addr_i,
    input  logic        restart_req_i,
    output logic        core_rst_no,
    output logic        core_fetch_en_o,
    output logic [31:0] core_boot_addr_o,
    output logic        boot_done_o,
    output logic [1:0]  boot_err_o
);

    localparam logic [31:0] JtagAddr = BaseAddr + BootROMOffset;
    localparam logic [32:0] MemLo    = {1'b0, BaseAddr} + {1'b0, MemOffset};
    localparam logic [32:0] MemHi    = MemLo + {1'b0, MemBytes};

    localparam int RW = (ResetCycles > 1) ? $clog2(ResetCycles) : 1;
    localparam int TW = (TimeoutCycles == 32'd0) ? 1 : $clog2({1'b0, TimeoutCycles} + 33'd1);

    localparam logic [RW-1:0] RstLast  = RW'(ResetCycles - 1);
    localparam logic [TW-1:0] TmoLimit = TW'(TimeoutCycles);

    localparam logic [1:0] ErrNone    = 2'b00;
    localparam logic [1:0] ErrTimeout = 2'b01;
    localparam logic [1:0] ErrEntry   = 2'b10;
    localparam logic [1:0] ErrMode    = 2'b11;

    typedef enum logic [2:0] {
        StReset,
        StSample,
        StWaitJtag,
        StWaitPreload,
        StLaunch,
        StRun,
        StError
    } state_e;

    state_e          state_q;
    logic [RW-1:0]   rstCnt_q;
    logic [TW-1:0]   tmoCnt_q;
    logic [TW-1:0]   tmoCnt_d;
    logic            tmoHit;
    logic            entryOk;
    logic [32:0]     entryExt;

    logic            coreRst_q;
    logic            fetchEn_q;
    logic [31:0]     bootAddr_q;
    logic            done_q;
    logic [1:0]      err_q;

    // Bounds are compared one bit wider so a window near the top of memory cannot wrap.
    assign entryExt = {1'b0, entry_addr_i};
    assign entryOk  = (entry_addr_i[1:0] == 2'b00) && (entryExt >= MemLo) && (entryExt < MemHi);

    assign tmoCnt_d = (tmoCnt_q == TmoLimit) ? tmoCnt_q : tmoCnt_q + TW'(1);
    assign tmoHit   = (TimeoutCycles != 32'd0) && (tmoCnt_d == TmoLimit);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StReset;
            rstCnt_q   <= '0;
            tmoCnt_q   <= '0;
            coreRst_q  <= 1'b0;
            fetchEn_q  <= 1'b0;
            bootAddr_q <= JtagAddr;
            done_q     <= 1'b0;
            err_q      <= ErrNone;
        end else if (restart_req_i) begin
            // The boot address is deliberately kept across a restart.
            state_q   <= StReset;
            rstCnt_q  <= '0;
            tmoCnt_q  <= '0;
            coreRst_q <= 1'b0;
            fetchEn_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= ErrNone;
        end else begin
            case (state_q)
                StReset: begin
                    if (rstCnt_q == RstLast) begin
                        rstCnt_q  <= '0;
                        coreRst_q <= 1'b1;
                        state_q   <= StSample;
                    end else begin
                        rstCnt_q <= rstCnt_q + RW'(1);
                    end
                end
                StSample: begin
                    tmoCnt_q <= '0;
                    case (bootmode_i)
                        2'b00:   state_q <= StWaitJtag;
                        2'b01:   state_q <= StWaitPreload;
                        default: begin
                            coreRst_q <= 1'b0;
                            err_q     <= ErrMode;
                            state_q   <= StError;
                        end
                    endcase
                end
                StWaitJtag: begin
                    tmoCnt_q <= tmoCnt_d;
                    if (fetch_en_req_i) begin
                        bootAddr_q <= JtagAddr;
                        state_q    <= StLaunch;
                    end else if (tmoHit) begin
                        coreRst_q <= 1'b0;
                        err_q     <= ErrTimeout;
                        state_q   <= StError;
                    end
                end
                StWaitPreload: begin
                    tmoCnt_q <= tmoCnt_d;
                    if (entry_valid_i) begin
                        if (entryOk) begin
                            bootAddr_q <= entry_addr_i;
                            state_q    <= StLaunch;
                        end else begin
                            coreRst_q <= 1'b0;
                            err_q     <= ErrEntry;
                            state_q   <= StError;
                        end
                    end else if (tmoHit) begin
                        coreRst_q <= 1'b0;
                        err_q     <= ErrTimeout;
                        state_q   <= StError;
                    end
                end
                StLaunch: begin
                    fetchEn_q <= 1'b1;
                    done_q    <= 1'b1;
                    state_q   <= StRun;
                end
                StRun: begin
                    state_q <= StRun;
                end
                StError: begin
                    state_q <= StError;
                end
                default: begin
                    coreRst_q <= 1'b0;
                    fetchEn_q <= 1'b0;
                    done_q    <= 1'b0;
                    state_q   <= StReset;
                end
            endcase
        end
    end

    assign core_rst_no      = coreRst_q;
    assign core_fetch_en_o  = fetchEn_q;
    assign core_boot_addr_o = bootAddr_q;
    assign boot_done_o      = done_q;
    assign boot_err_o       = err_q;

endmodule
